// File: rtl/key_onehot4.sv
// key_onehot4: synchronise and debounce four push-buttons, then present one fixed-priority
// one-hot key event on d with a valid/ack handshake. Define KEY_AUTOREPEAT_EN for auto-repeat.
module key_onehot4 #(
  parameter int DB_CYCLES     = 16,
  parameter int DB_W          = 5,
  parameter int REPEAT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       ack,
  output logic [3:0] d,
  output logic       valid
);

  // state   | meaning
  // IDLE    | no event pending, waiting for any debounced press
  // HOLD    | event presented on d/valid, waiting for ack
  // RELEASE | event consumed, waiting until every key is debounced released
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  if ((2 ** DB_W) <= DB_CYCLES) begin : g_bad_db_w
    $error("DB_W is too narrow to count DB_CYCLES");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end

  logic [3:0]            s1_q, s2_q;
  logic [3:0]            k_db_q, k_db_d;
  logic [3:0][DB_W-1:0]  cnt_q, cnt_d;
  state_t                state_q, state_d;
  logic [3:0]            d_q, d_d;
  logic                  valid_q, valid_d;
  logic [3:0]            win;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0]         rep_q, rep_d;
  logic [3:0]            last_q, last_d;
`endif

  always_comb begin
    k_db_d = k_db_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] == k_db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_W'(DB_CYCLES - 1)) begin
        k_db_d[i] = ~k_db_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
  end

  always_comb begin
    if (k_db_q[3])      win = 4'b1000;
    else if (k_db_q[2]) win = 4'b0100;
    else if (k_db_q[1]) win = 4'b0010;
    else if (k_db_q[0]) win = 4'b0001;
    else                win = 4'b0000;
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    valid_d = valid_q;
`ifdef KEY_AUTOREPEAT_EN
    rep_d   = rep_q;
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|k_db_q) begin
          d_d     = win;
          valid_d = 1'b1;
          state_d = HOLD;
`ifdef KEY_AUTOREPEAT_EN
          last_d  = win;
`endif
        end
      end
      HOLD: begin
        if (ack) begin
          d_d     = 4'b0000;
          valid_d = 1'b0;
          state_d = RELEASE;
`ifdef KEY_AUTOREPEAT_EN
          rep_d   = '0;
`endif
        end
      end
      RELEASE: begin
        if (k_db_q == 4'b0000) begin
          state_d = IDLE;
        end
`ifdef KEY_AUTOREPEAT_EN
        else if ((k_db_q & last_q) == 4'b0000) begin
          rep_d = '0;
        end else if (rep_q == RW'(REPEAT_CYCLES - 1)) begin
          d_d     = last_q;
          valid_d = 1'b1;
          state_d = HOLD;
          rep_d   = '0;
        end else begin
          rep_d = rep_q + RW'(1);
        end
`endif
      end
      default: begin
        d_d     = 4'b0000;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      k_db_q  <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      d_q     <= '0;
      valid_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= '0;
      last_q  <= '0;
`endif
    end else begin
      s1_q    <= key;
      s2_q    <= s1_q;
      k_db_q  <= k_db_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      d_q     <= d_d;
      valid_q <= valid_d;
`ifdef KEY_AUTOREPEAT_EN
      rep_q   <= rep_d;
      last_q  <= last_d;
`endif
    end
  end

  assign d     = d_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_key_onehot4.sv
// Testbench for key_onehot4: directed and random key patterns, with a history-based reference
// model feeding an event scoreboard that a separate monitor drains.
module tb_key_onehot4;
  localparam int DB_CYCLES     = 16;
  localparam int DB_W          = 5;
  localparam int REPEAT_CYCLES = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key = 4'b0000;
  logic       ack = 1'b0;
  logic [3:0] d;
  logic       valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ev_count = 0;
  int last_rise = -1;

  typedef struct {
    logic [3:0] code;
    int         at_edge;
  } ev_t;
  ev_t exp_q[$];

  key_onehot4 #(
    .DB_CYCLES(DB_CYCLES),
    .DB_W(DB_W),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .ack(ack),
    .d(d),
    .valid(valid)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: a key's debounced level flips once the synchronised line has disagreed
  // with it on each of the last DB_CYCLES edges; the event logic works from the old level.
  logic [3:0] m_s1 = 4'b0, m_s2 = 4'b0, m_kdb = 4'b0, m_last = 4'b0;
  logic [3:0] s2_hist[$];
  int         m_state = 0;
  int         m_rep = 0;
  logic [3:0] m_win;
  bit         all_diff;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_s1 = 4'b0; m_s2 = 4'b0; m_kdb = 4'b0; m_last = 4'b0;
      m_state = 0; m_rep = 0;
      s2_hist.delete();
    end else begin
      case (m_state)
        0: if (m_kdb != 4'b0) begin
             m_win = 4'b0;
             for (int i = 0; i < 4; i++) if (m_kdb[i]) m_win = 4'(1 << i);
             m_last = m_win;
             exp_q.push_back('{code: m_win, at_edge: cyc});
             m_state = 1;
           end
        1: if (ack) begin m_state = 2; m_rep = 0; end
        2: begin
             if (m_kdb == 4'b0) m_state = 0;
`ifdef KEY_AUTOREPEAT_EN
             else if ((m_kdb & m_last) == 4'b0) m_rep = 0;
             else if (m_rep == REPEAT_CYCLES - 1) begin
               exp_q.push_back('{code: m_last, at_edge: cyc});
               m_state = 1;
               m_rep = 0;
             end else m_rep++;
`endif
           end
        default: m_state = 0;
      endcase
      s2_hist.push_back(m_s2);
      if (s2_hist.size() > DB_CYCLES) void'(s2_hist.pop_front());
      for (int i = 0; i < 4; i++) begin
        if (s2_hist.size() == DB_CYCLES) begin
          all_diff = 1'b1;
          foreach (s2_hist[j]) if (s2_hist[j][i] == m_kdb[i]) all_diff = 1'b0;
          if (all_diff) m_kdb[i] = ~m_kdb[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = key;
    end
  end

  logic valid_seen = 1'b0;
  ev_t  got;

  always @(negedge clk) begin
    if (valid && !valid_seen) begin
      ev_count++;
      last_rise = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual_d=%b required=no_event", d);
      end else begin
        got = exp_q.pop_front();
        chk("event_d", int'(d), int'(got.code));
        chk("event_edge", cyc, got.at_edge);
      end
    end
    if (!valid) chk("idle_d_zero", int'(d), 0);
    valid_seen = valid;
  end

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
  endtask

  int n0, c0, hi;

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    chk("reset_d", int'(d), 0);
    chk("reset_valid", int'(valid), 0);

    // single key, exact latency, one ack, no repeat while held
    c0 = cyc;
    key = 4'b0010;
    wait_cyc(30);
    chk("press_latency", last_rise, c0 + 19);
    chk("hold_d", int'(d), 2);
    chk("hold_valid", int'(valid), 1);
    ack_pulse();
    chk("ack_d", int'(d), 0);
    chk("ack_valid", int'(valid), 0);
    #1 n0 = ev_count;
    wait_cyc(100);
    #1 chk("no_second_event", ev_count, n0);
    key = 4'b0000;
    wait_cyc(40);

    // reset in the middle of HOLD
    key = 4'b0100;
    wait_cyc(25);
    chk("prereset_d", int'(d), 4);
    chk("prereset_valid", int'(valid), 1);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    chk("midreset_d", int'(d), 0);
    chk("midreset_valid", int'(valid), 0);
    #1 n0 = ev_count;
    wait_cyc(10);
    #1 chk("no_event_after_reset", ev_count, n0);
    wait_cyc(20);
    chk("fresh_press_d", int'(d), 4);
    ack_pulse();
    key = 4'b0000;
    wait_cyc(40);

    // bouncing shorter than the debounce window
    #1 n0 = ev_count;
    for (int t = 0; t < 25; t++) begin
      key = key ^ 4'b0010;
      wait_cyc(8);
      chk("glitch_valid", int'(valid), 0);
    end
    key = 4'b0000;
    wait_cyc(20);
    #1 chk("glitch_no_event", ev_count, n0);

    // priority
    key = 4'b1011;
    wait_cyc(30);
    chk("prio_1011", int'(d), 8);
    ack_pulse();
    key = 4'b0000;
    wait_cyc(40);
    key = 4'b0011;
    wait_cyc(30);
    chk("prio_0011", int'(d), 2);
    ack_pulse();
    key = 4'b0000;
    wait_cyc(40);

    // ack held high permanently: two separate one-cycle pulses
    ack = 1'b1;
    #1 n0 = ev_count;
    hi = 0;
    for (int p = 0; p < 2; p++) begin
      key = 4'b0001;
      for (int t = 0; t < 30; t++) begin wait_cyc(1); hi += int'(valid); end
      key = 4'b0000;
      for (int t = 0; t < 40; t++) begin wait_cyc(1); hi += int'(valid); end
    end
    ack = 1'b0;
    #1 chk("ack_held_events", ev_count, n0 + 2);
    chk("ack_held_valid_cycles", hi, 2);

    // randomized key patterns with random acks
    for (int it = 0; it < 40; it++) begin
      key = 4'($urandom_range(0, 15));
      repeat ($urandom_range(3, 40)) begin
        ack = ($urandom_range(0, 3) == 0);
        wait_cyc(1);
      end
    end
    key = 4'b0000;
    ack = 1'b0;
    wait_cyc(60);
    ack_pulse();
    wait_cyc(60);

`ifdef KEY_AUTOREPEAT_EN
    ack = 1'b1;
    #1 n0 = ev_count;
    key = 4'b0100;
    wait_cyc(250);
    #1 chk("autorepeat_events", ev_count, n0 + 4);
    key = 4'b0000;
    ack = 1'b0;
    wait_cyc(60);
`endif

    wait_cyc(20);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
